// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: FETCH/DECODE/EXEC/MEM/WB control sequencer for a multi-cycle RV32I datapath.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes; otherwise they retire as NOPs.
module multicycle_ctrl_fsm #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       instr_op_i,
    input  logic             imem_ready_i,
    input  logic             dmem_ready_i,
    output logic             imem_req_o,
    output logic             dmem_req_o,
    output logic             IRWrite_o,
    output logic             PCWrite_o,
    output logic             RegWrite_o,
    output logic             MemRead_o,
    output logic             MemWrite_o,
    output logic [1:0]       MemtoReg_o,
    output logic             ALUSrc_o,
    output logic [1:0]       ALUop_o,
    output logic             Branch_o,
    output logic             Jal_o,
    output logic             Jalr_o,
    output logic [CNT_W-1:0] instret_o,
    output logic [2:0]       state_o,
    output logic             bus_err_o
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [3:0] C_LOAD   = 4'd0;
    localparam logic [3:0] C_STORE  = 4'd1;
    localparam logic [3:0] C_BRANCH = 4'd2;
    localparam logic [3:0] C_OP     = 4'd3;
    localparam logic [3:0] C_OP_IMM = 4'd4;
    localparam logic [3:0] C_JAL    = 4'd5;
    localparam logic [3:0] C_JALR   = 4'd6;
    localparam logic [3:0] C_LUI    = 4'd7;
    localparam logic [3:0] C_AUIPC  = 4'd8;
    localparam logic [3:0] C_UNK    = 4'd9;

    localparam logic [7:0] MAX_WAIT_C = MAX_WAIT[7:0];

    function automatic logic [3:0] decode_class(input logic [4:0] op);
        case (op)
            5'b00000: decode_class = C_LOAD;
            5'b01000: decode_class = C_STORE;
            5'b11000: decode_class = C_BRANCH;
            5'b01100: decode_class = C_OP;
            5'b00100: decode_class = C_OP_IMM;
            5'b11011: decode_class = C_JAL;
            5'b11001: decode_class = C_JALR;
            5'b01101: decode_class = C_LUI;
            5'b00101: decode_class = C_AUIPC;
            default:  decode_class = C_UNK;
        endcase
    endfunction

    function automatic logic alu_src_f(input logic [3:0] cls);
        case (cls)
            C_LOAD, C_STORE, C_OP_IMM: alu_src_f = 1'b1;
            default:                   alu_src_f = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_op_f(input logic [3:0] cls);
        case (cls)
            C_BRANCH:       alu_op_f = 2'b01;
            C_OP, C_OP_IMM: alu_op_f = 2'b10;
            default:        alu_op_f = 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] mem_to_reg_f(input logic [3:0] cls);
        case (cls)
            C_LOAD:          mem_to_reg_f = 2'b01;
            C_JAL, C_JALR:   mem_to_reg_f = 2'b10;
            C_LUI, C_AUIPC:  mem_to_reg_f = 2'b11;
            default:         mem_to_reg_f = 2'b00;
        endcase
    endfunction

    logic [2:0]       state_q, state_d;
    logic [3:0]       cls_q, cls_d;
    logic [7:0]       wait_q, wait_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [3:0] dec_cls_s;
    logic [7:0] wait_inc_s;
    logic       timeout_s;
    logic       imem_req_s, dmem_req_s, ir_write_s, pc_write_s, reg_write_s;
    logic       mem_read_s, mem_write_s, alu_src_s, branch_s, jal_s, jalr_s;
    logic [1:0] mem_to_reg_s, alu_op_s;
    logic       unused_op_s;

    assign dec_cls_s   = decode_class(instr_op_i[6:2]);
    assign wait_inc_s  = wait_q + 8'd1;
    assign timeout_s   = (wait_inc_s == MAX_WAIT_C);
    assign unused_op_s = ^instr_op_i[1:0];

    // Next-state, wait-counter and per-state control decode.
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        wait_d       = 8'd0;
        bus_err_d    = bus_err_q;
        imem_req_s   = 1'b0;
        dmem_req_s   = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        mem_to_reg_s = 2'b00;
        alu_src_s    = 1'b0;
        alu_op_s     = 2'b00;
        branch_s     = 1'b0;
        jal_s        = 1'b0;
        jalr_s       = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_s = 1'b1;
                if (imem_ready_i) begin
                    ir_write_s = 1'b1;
                    state_d    = S_DECODE;
                end else if (timeout_s) begin
                    state_d   = S_ERR;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_inc_s;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls_s;
                if (dec_cls_s != C_UNK) begin
                    state_d = S_EXEC;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    pc_write_s = 1'b1;
                    state_d    = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                alu_src_s = alu_src_f(cls_q);
                alu_op_s  = alu_op_f(cls_q);
                case (cls_q)
                    C_BRANCH: begin
                        pc_write_s = 1'b1;
                        branch_s   = 1'b1;
                        state_d    = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                alu_src_s   = alu_src_f(cls_q);
                alu_op_s    = alu_op_f(cls_q);
                dmem_req_s  = 1'b1;
                mem_read_s  = (cls_q == C_LOAD);
                mem_write_s = (cls_q == C_STORE);
                if (dmem_ready_i) begin
                    if (cls_q == C_STORE) begin
                        pc_write_s = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout_s) begin
                    state_d   = S_ERR;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_inc_s;
                end
            end
            S_WB: begin
                alu_src_s    = alu_src_f(cls_q);
                alu_op_s     = alu_op_f(cls_q);
                reg_write_s  = 1'b1;
                mem_to_reg_s = mem_to_reg_f(cls_q);
                pc_write_s   = 1'b1;
                jal_s        = (cls_q == C_JAL);
                jalr_s       = (cls_q == C_JALR);
                state_d      = S_FETCH;
            end
            S_ERR:   state_d = S_ERR;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        instret_d = pc_write_s ? (instret_q + CNT_W'(1)) : instret_q;
    end

    // State, held class, wait counter, sticky bus error and retire counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_FETCH;
            cls_q     <= C_LOAD;
            wait_q    <= 8'd0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
        end
    end

    // Controls are forced low while reset is asserted so an aborted instruction never commits.
    assign imem_req_o = imem_req_s  & ~rst_i;
    assign dmem_req_o = dmem_req_s  & ~rst_i;
    assign IRWrite_o  = ir_write_s  & ~rst_i;
    assign PCWrite_o  = pc_write_s  & ~rst_i;
    assign RegWrite_o = reg_write_s & ~rst_i;
    assign MemRead_o  = mem_read_s  & ~rst_i;
    assign MemWrite_o = mem_write_s & ~rst_i;
    assign MemtoReg_o = mem_to_reg_s & {2{~rst_i}};
    assign ALUSrc_o   = alu_src_s   & ~rst_i;
    assign ALUop_o    = alu_op_s    & {2{~rst_i}};
    assign Branch_o   = branch_s    & ~rst_i;
    assign Jal_o      = jal_s       & ~rst_i;
    assign Jalr_o     = jalr_s      & ~rst_i;
    assign instret_o  = instret_q;
    assign state_o    = state_q;
    assign bus_err_o  = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm; honours ILLEGAL_TRAP_EN when defined.
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [6:0]  instr_op_i = 7'd0;
    logic        imem_ready_i = 1'b0;
    logic        dmem_ready_i = 1'b0;
    logic        imem_req_o, dmem_req_o, IRWrite_o, PCWrite_o, RegWrite_o;
    logic        MemRead_o, MemWrite_o, ALUSrc_o, Branch_o, Jal_o, Jalr_o, bus_err_o;
    logic [1:0]  MemtoReg_o, ALUop_o;
    logic [31:0] instret_o;
    logic [2:0]  state_o;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_instret = 32'd0;

    multicycle_ctrl_fsm #(.CNT_W(32), .MAX_WAIT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i),
        .imem_ready_i(imem_ready_i), .dmem_ready_i(dmem_ready_i),
        .imem_req_o(imem_req_o), .dmem_req_o(dmem_req_o), .IRWrite_o(IRWrite_o),
        .PCWrite_o(PCWrite_o), .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o), .ALUSrc_o(ALUSrc_o),
        .ALUop_o(ALUop_o), .Branch_o(Branch_o), .Jal_o(Jal_o), .Jalr_o(Jalr_o),
        .instret_o(instret_o), .state_o(state_o), .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One cycle of stimulus: inputs change on the falling edge, outputs are sampled 1 time unit later.
    task automatic drive(input logic ir, input logic dr, input logic [6:0] op);
        @(negedge clk_i);
        rst_i        = 1'b0;
        imem_ready_i = ir;
        dmem_ready_i = dr;
        instr_op_i   = op;
        #1;
    endtask

    // Assert reset for one rising edge; the next drive() call releases it.
    task automatic do_reset();
        @(negedge clk_i);
        rst_i        = 1'b1;
        imem_ready_i = 1'b0;
        dmem_ready_i = 1'b0;
        #1;
        exp_instret = 32'd0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rst_imem_req got=%0d exp=0", imem_req_o); end
        checks++; if ({PCWrite_o, RegWrite_o, IRWrite_o, dmem_req_o} !== 4'b0000) begin failures++; $display("FAIL rst_ctrls got=%b exp=0000", {PCWrite_o, RegWrite_o, IRWrite_o, dmem_req_o}); end
        drive(1'b0, 1'b0, 7'd0);
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state_o); end
        checks++; if (instret_o !== 32'd0) begin failures++; $display("FAIL rst_instret got=%0d exp=0", instret_o); end
        checks++; if (bus_err_o !== 1'b0) begin failures++; $display("FAIL rst_bus_err got=%0d exp=0", bus_err_o); end
        checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL rst_fetch_req got=%0d exp=1", imem_req_o); end
    endtask

    task automatic test_rtype();
        drive(1'b1, 1'b0, OP_R);
        checks++; if ({state_o, IRWrite_o} !== {3'd0, 1'b1}) begin failures++; $display("FAIL r_fetch st/irw got=%0d/%0d exp=0/1", state_o, IRWrite_o); end
        drive(1'b0, 1'b0, OP_R);
        checks++; if ({state_o, IRWrite_o, PCWrite_o} !== {3'd1, 2'b00}) begin failures++; $display("FAIL r_decode st/irw/pcw got=%0d/%0d/%0d exp=1/0/0", state_o, IRWrite_o, PCWrite_o); end
        drive(1'b0, 1'b1, 7'd0);
        checks++; if ({state_o, ALUop_o, ALUSrc_o, dmem_req_o} !== {3'd2, 2'b10, 1'b0, 1'b0}) begin failures++; $display("FAIL r_exec st/aluop/src/dreq got=%0d/%b/%0d/%0d exp=2/10/0/0", state_o, ALUop_o, ALUSrc_o, dmem_req_o); end
        drive(1'b0, 1'b0, 7'd0);
        checks++; if (state_o !== 3'd4) begin failures++; $display("FAIL r_wb_state got=%0d exp=4", state_o); end
        checks++; if ({RegWrite_o, ALUop_o, ALUSrc_o, MemtoReg_o, PCWrite_o} !== {1'b1, 2'b10, 1'b0, 2'b00, 1'b1}) begin failures++; $display("FAIL r_wb_ctrls got=%b exp=1100001", {RegWrite_o, ALUop_o, ALUSrc_o, MemtoReg_o, PCWrite_o}); end
        exp_instret = exp_instret + 32'd1;
        drive(1'b0, 1'b0, 7'd0);
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL r_back_fetch got=%0d exp=0", state_o); end
        checks++; if (instret_o !== exp_instret) begin failures++; $display("FAIL r_instret got=%0d exp=%0d", instret_o, exp_instret); end
    endtask

    task automatic test_load_wait();
        drive(1'b1, 1'b0, OP_LW);
        drive(1'b0, 1'b0, OP_LW);
        drive(1'b0, 1'b0, 7'd0);
        checks++; if ({state_o, ALUSrc_o, ALUop_o} !== {3'd2, 1'b1, 2'b00}) begin failures++; $display("FAIL lw_exec st/src/aluop got=%0d/%0d/%b exp=2/1/00", state_o, ALUSrc_o, ALUop_o); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i == 3), 7'd0);
            checks++; if ({state_o, dmem_req_o, MemRead_o, MemWrite_o, PCWrite_o} !== {3'd3, 4'b1100}) begin failures++; $display("FAIL lw_mem_%0d got=%0d/%b exp=3/1100", i, state_o, {dmem_req_o, MemRead_o, MemWrite_o, PCWrite_o}); end
        end
        drive(1'b0, 1'b0, 7'd0);
        checks++; if ({state_o, MemtoReg_o, RegWrite_o, PCWrite_o, dmem_req_o} !== {3'd4, 2'b01, 2'b11, 1'b0}) begin failures++; $display("FAIL lw_wb st/m2r/rw/pcw/dreq got=%0d/%b/%0d/%0d/%0d exp=4/01/1/1/0", state_o, MemtoReg_o, RegWrite_o, PCWrite_o, dmem_req_o); end
        exp_instret = exp_instret + 32'd1;
        drive(1'b0, 1'b0, 7'd0);
        checks++; if ({state_o, instret_o} !== {3'd0, exp_instret}) begin failures++; $display("FAIL lw_done st/instret got=%0d/%0d exp=0/%0d", state_o, instret_o, exp_instret); end
    endtask

    task automatic test_store_branch();
        drive(1'b1, 1'b0, OP_SW);
        drive(1'b0, 1'b0, OP_SW);
        drive(1'b0, 1'b0, 7'd0);
        drive(1'b0, 1'b1, 7'd0);
        checks++; if ({state_o, MemWrite_o, PCWrite_o, RegWrite_o, MemRead_o} !== {3'd3, 4'b1100}) begin failures++; $display("FAIL sw_mem got=%0d/%b exp=3/1100", state_o, {MemWrite_o, PCWrite_o, RegWrite_o, MemRead_o}); end
        exp_instret = exp_instret + 32'd1;
        drive(1'b1, 1'b0, OP_BEQ);
        checks++; if ({state_o, RegWrite_o} !== {3'd0, 1'b0}) begin failures++; $display("FAIL sw_to_fetch st/rw got=%0d/%0d exp=0/0", state_o, RegWrite_o); end
        drive(1'b0, 1'b0, OP_BEQ);
        drive(1'b0, 1'b0, 7'd0);
        checks++; if ({state_o, Branch_o, ALUop_o, PCWrite_o, ALUSrc_o, RegWrite_o} !== {3'd2, 1'b1, 2'b01, 1'b1, 2'b00}) begin failures++; $display("FAIL beq_exec got=%0d/%b exp=2/101100", state_o, {Branch_o, ALUop_o, PCWrite_o, ALUSrc_o, RegWrite_o}); end
        exp_instret = exp_instret + 32'd1;
        drive(1'b0, 1'b0, 7'd0);
        checks++; if ({state_o, instret_o} !== {3'd0, exp_instret}) begin failures++; $display("FAIL beq_done st/instret got=%0d/%0d exp=0/%0d", state_o, instret_o, exp_instret); end
    endtask

    task automatic test_jumps_upper();
        drive(1'b1, 1'b0, OP_JAL);
        drive(1'b0, 1'b0, OP_JAL);
        drive(1'b0, 1'b0, 7'd0);
        drive(1'b0, 1'b0, 7'd0);
        checks++; if ({state_o, Jal_o, Jalr_o, MemtoReg_o, RegWrite_o, ALUop_o} !== {3'd4, 2'b10, 2'b10, 1'b1, 2'b00}) begin failures++; $display("FAIL jal_wb got=%0d/%b exp=4/10101 00", state_o, {Jal_o, Jalr_o, MemtoReg_o, RegWrite_o, ALUop_o}); end
        drive(1'b1, 1'b0, OP_JALR);
        drive(1'b0, 1'b0, OP_JALR);
        drive(1'b0, 1'b0, 7'd0);
        drive(1'b0, 1'b0, 7'd0);
        checks++; if ({state_o, Jal_o, Jalr_o, MemtoReg_o} !== {3'd4, 2'b01, 2'b10}) begin failures++; $display("FAIL jalr_wb got=%0d/%b exp=4/0110", state_o, {Jal_o, Jalr_o, MemtoReg_o}); end
        drive(1'b1, 1'b0, OP_AUIPC);
        drive(1'b0, 1'b0, OP_AUIPC);
        drive(1'b0, 1'b0, 7'd0);
        checks++; if ({state_o, ALUSrc_o, ALUop_o} !== {3'd2, 1'b0, 2'b00}) begin failures++; $display("FAIL auipc_exec got=%0d/%0d/%b exp=2/0/00", state_o, ALUSrc_o, ALUop_o); end
        drive(1'b0, 1'b0, 7'd0);
        checks++; if ({state_o, Jal_o, Jalr_o, MemtoReg_o, PCWrite_o} !== {3'd4, 2'b00, 2'b11, 1'b1}) begin failures++; $display("FAIL auipc_wb got=%0d/%b exp=4/00111", state_o, {Jal_o, Jalr_o, MemtoReg_o, PCWrite_o}); end
        exp_instret = exp_instret + 32'd3;
        drive(1'b0, 1'b0, 7'd0);
        checks++; if (instret_o !== exp_instret) begin failures++; $display("FAIL jumps_instret got=%0d exp=%0d", instret_o, exp_instret); end
    endtask

    task automatic test_timeout();
        do_reset();
        // Seven un-acked fetch cycles, then an ack on the eighth: the ack must win.
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, OP_I);
        drive(1'b1, 1'b0, OP_I);
        checks++; if ({state_o, IRWrite_o} !== {3'd0, 1'b1}) begin failures++; $display("FAIL ack_at_max st/irw got=%0d/%0d exp=0/1", state_o, IRWrite_o); end
        drive(1'b0, 1'b0, OP_I);
        checks++; if ({state_o, bus_err_o} !== {3'd1, 1'b0}) begin failures++; $display("FAIL ack_at_max_decode st/err got=%0d/%0d exp=1/0", state_o, bus_err_o); end
        drive(1'b0, 1'b0, 7'd0);
        checks++; if ({ALUSrc_o, ALUop_o} !== 3'b110) begin failures++; $display("FAIL opimm_exec src/aluop got=%0d/%b exp=1/10", ALUSrc_o, ALUop_o); end
        drive(1'b0, 1'b0, 7'd0);
        exp_instret = exp_instret + 32'd1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 7'd0);
            checks++; if ({state_o, imem_req_o, bus_err_o} !== {3'd0, 2'b10}) begin failures++; $display("FAIL wait_cycle_%0d got=%0d/%0d/%0d exp=0/1/0", i, state_o, imem_req_o, bus_err_o); end
        end
        drive(1'b0, 1'b0, 7'd0);
        checks++; if ({state_o, bus_err_o, imem_req_o} !== {3'd5, 2'b10}) begin failures++; $display("FAIL err_entry st/err/req got=%0d/%0d/%0d exp=5/1/0", state_o, bus_err_o, imem_req_o); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, OP_R);
            checks++; if ({state_o, bus_err_o, IRWrite_o, PCWrite_o, dmem_req_o} !== {3'd5, 4'b1000}) begin failures++; $display("FAIL err_sticky_%0d got=%0d/%b exp=5/1000", i, state_o, {bus_err_o, IRWrite_o, PCWrite_o, dmem_req_o}); end
        end
        checks++; if (instret_o !== exp_instret) begin failures++; $display("FAIL err_instret got=%0d exp=%0d", instret_o, exp_instret); end
        do_reset();
        drive(1'b0, 1'b0, 7'd0);
        checks++; if ({state_o, bus_err_o, instret_o} !== {3'd0, 1'b0, 32'd0}) begin failures++; $display("FAIL err_reset st/err/instret got=%0d/%0d/%0d exp=0/0/0", state_o, bus_err_o, instret_o); end
    endtask

    task automatic test_reset_abort();
        drive(1'b1, 1'b0, OP_R);
        drive(1'b0, 1'b0, OP_R);
        drive(1'b0, 1'b0, 7'd0);
        drive(1'b0, 1'b0, 7'd0);
        rst_i = 1'b1;
        #1;
        checks++; if ({PCWrite_o, RegWrite_o, imem_req_o} !== 3'b000) begin failures++; $display("FAIL abort_ctrls got=%b exp=000", {PCWrite_o, RegWrite_o, imem_req_o}); end
        exp_instret = 32'd0;
        drive(1'b0, 1'b0, 7'd0);
        checks++; if ({state_o, instret_o} !== {3'd0, 32'd0}) begin failures++; $display("FAIL abort_state st/instret got=%0d/%0d exp=0/0", state_o, instret_o); end
    endtask

    task automatic test_illegal();
        drive(1'b1, 1'b0, OP_BAD);
        drive(1'b0, 1'b0, OP_BAD);
`ifdef ILLEGAL_TRAP_EN
        checks++; if ({state_o, PCWrite_o} !== {3'd1, 1'b0}) begin failures++; $display("FAIL bad_decode st/pcw got=%0d/%0d exp=1/0", state_o, PCWrite_o); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, OP_R);
            checks++; if ({state_o, imem_req_o, IRWrite_o, PCWrite_o, bus_err_o} !== {3'd6, 4'b0000}) begin failures++; $display("FAIL trap_hold_%0d got=%0d/%b exp=6/0000", i, state_o, {imem_req_o, IRWrite_o, PCWrite_o, bus_err_o}); end
        end
        checks++; if (instret_o !== exp_instret) begin failures++; $display("FAIL trap_instret got=%0d exp=%0d", instret_o, exp_instret); end
`else
        checks++; if ({state_o, PCWrite_o, RegWrite_o} !== {3'd1, 2'b10}) begin failures++; $display("FAIL bad_decode st/pcw/rw got=%0d/%0d/%0d exp=1/1/0", state_o, PCWrite_o, RegWrite_o); end
        exp_instret = exp_instret + 32'd1;
        drive(1'b0, 1'b0, 7'd0);
        checks++; if ({state_o, instret_o} !== {3'd0, exp_instret}) begin failures++; $display("FAIL bad_skip st/instret got=%0d/%0d exp=0/%0d", state_o, instret_o, exp_instret); end
`endif
        do_reset();
        drive(1'b0, 1'b0, 7'd0);
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL final_reset got=%0d exp=0", state_o); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store_branch();
        test_jumps_upper();
        test_timeout();
        test_reset_abort();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
